ysyx_23060180_lsu: RTL

//  Load/store unit for the MEMORY stage, downstream of the core's EXECUTE stage.

---
 rtl/ysyx_23060180_lsu.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060180_lsu.sv
// MEMORY-stage load/store unit: lane select, store masks, sign/zero extension, ack timeout.
// Latency 2 cycles accept->rsp_valid on a first-cycle ack, 1 cycle on an accept-time error; no rsp backpressure.
// Optional macro LSU_MISALIGN_CHECK_EN flags misaligned H/W accesses as errors instead of issuing them.
module ysyx_23060180_lsu #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]  state;
    logic [15:0] cnt;
    logic        lat_we;
    logic [2:0]  lat_func3;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;

    logic        accept;
    logic [1:0]  off;
    logic        illegal;
    logic        misalign;
    logic        acc_err;
    logic [31:0] st_wdata;
    logic [3:0]  st_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        timeout;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];

    // Stores only have SB/SH/SW; loads additionally allow BU/HU.
    always_comb begin
        illegal = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
                  (req_func3 == 3'b111) || (req_we && req_func3[2]);
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((req_func3[1:0] == 2'b01) && off[0]) ||
                   ((req_func3[1:0] == 2'b10) && (off != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = illegal || misalign;
    end

    always_comb begin
        st_wdata = req_wdata;
        st_mask  = 4'b1111;
        case (req_func3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_mask  = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_mask  = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                st_wdata = req_wdata;
                st_mask  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_func3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // cnt counts completed REQ cycles; ACK_TIMEOUT==0 disables the limit.
    assign timeout = (ACK_TIMEOUT != 0) && (cnt == 16'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            lat_we    <= 1'b0;
            lat_func3 <= 3'd0;
            lat_off   <= 2'd0;
            lat_rd    <= 5'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_func3 <= req_func3;
                        lat_off   <= off;
                        lat_rd    <= req_rd;
                        cnt       <= 16'd0;
                        if (acc_err) begin
                            state     <= S_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                            rsp_rd    <= req_we ? 5'd0 : req_rd;
                        end else begin
                            state     <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_we ? st_wdata : 32'd0;
                            mem_wmask <= req_we ? st_mask : 4'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state     <= S_RSP;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= lat_we ? 32'd0 : ld_data;
                        rsp_rd    <= lat_we ? 5'd0 : lat_rd;
                    end else if (timeout) begin
                        state     <= S_RSP;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_rd    <= lat_we ? 5'd0 : lat_rd;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RSP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_rd    <= 5'd0;
                    mem_req   <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
